// File: rtl/tcp_app_pkg.sv
// rtl/tcp_app_pkg.sv - shared widths, status codes and FSM states for the TX app responder
package tcp_app_pkg;

    localparam int SESSION_W = 16;
    localparam int STATUS_W  = 24;
    localparam int DATA_W    = 64;
    localparam int KEEP_W    = DATA_W / 8;

    localparam logic [7:0] CODE_OK       = 8'h00;
    localparam logic [7:0] CODE_CLOSED   = 8'h01;
    localparam logic [7:0] CODE_NO_SPACE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_STATUS,
        ST_DATA
    } state_t;

endpackage

// File: rtl/tx_credit_counter.sv
// rtl/tx_credit_counter.sv - TX buffer credit tracking with floor at zero and saturating returns
module tx_credit_counter #(
    parameter int TX_BUF_WORDS = 1024,
    parameter int CW           = $clog2(TX_BUF_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume,
    input  logic          ret_valid,
    input  logic [15:0]   ret_words,
    output logic [CW-1:0] credits,
    output logic          overflow
);

    localparam int SW = ((CW > 16) ? CW : 16) + 2;

    logic [CW-1:0] credits_q, credits_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] sum;

    // Return is applied before the consume so a simultaneous pair nets out in one cycle.
    always_comb begin
        sum = SW'(credits_q) + (ret_valid ? SW'(ret_words) : '0);
        if (consume && (sum != '0)) begin
            sum = sum - SW'(1);
        end
        credits_d  = credits_q;
        overflow_d = overflow_q;
        if (sum > SW'(TX_BUF_WORDS)) begin
            credits_d  = CW'(TX_BUF_WORDS);
            overflow_d = 1'b1;
        end else begin
            credits_d = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q  <= CW'(TX_BUF_WORDS);
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign credits  = credits_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/tcp_tx_app_responder.sv
// rtl/tcp_tx_app_responder.sv - grants application send requests and passes payload to the TCP engine
module tcp_tx_app_responder
    import tcp_app_pkg::*;
#(
    parameter int NUM_SESSIONS  = 16,
    parameter int TX_BUF_WORDS  = 1024,
    parameter int MAX_PKT_WORDS = 188
) (
    input  logic                              net_clk,
    input  logic                              net_rst,
    input  logic [NUM_SESSIONS-1:0]           session_open,
    input  logic                              s_axis_tx_metadata_tvalid,
    output logic                              s_axis_tx_metadata_tready,
    input  logic [SESSION_W-1:0]              s_axis_tx_metadata_tdata,
    output logic                              m_axis_tx_status_tvalid,
    input  logic                              m_axis_tx_status_tready,
    output logic [STATUS_W-1:0]               m_axis_tx_status_tdata,
    input  logic                              s_axis_tx_data_tvalid,
    output logic                              s_axis_tx_data_tready,
    input  logic [DATA_W-1:0]                 s_axis_tx_data_tdata,
    input  logic [KEEP_W-1:0]                 s_axis_tx_data_tkeep,
    input  logic                              s_axis_tx_data_tlast,
    output logic                              m_axis_tx_seg_tvalid,
    input  logic                              m_axis_tx_seg_tready,
    output logic [DATA_W-1:0]                 m_axis_tx_seg_tdata,
    output logic [KEEP_W-1:0]                 m_axis_tx_seg_tkeep,
    output logic                              m_axis_tx_seg_tlast,
    output logic [SESSION_W-1:0]              m_tx_seg_session,
    input  logic                              s_credit_valid,
    input  logic [15:0]                       s_credit_words,
    output logic [$clog2(TX_BUF_WORDS+1)-1:0] credits,
    output logic                              credit_overflow,
    output logic [31:0]                       stat_pkts_ok,
    output logic [31:0]                       stat_pkts_rej
);

    localparam int CW = $clog2(TX_BUF_WORDS + 1);

    state_t               state_q, state_d;
    logic [SESSION_W-1:0] session_q, session_d;
    logic [7:0]           code_q, code_d;
    logic                 status_valid_q, status_valid_d;
    logic [31:0]          ok_q, ok_d, rej_q, rej_d;
    logic                 open_sel;
    logic                 in_data;
    logic                 seg_hs;

    // Gate with reset so nothing leaks out on the first reset cycle, before state clears.
    assign in_data = (state_q == ST_DATA) && !net_rst;
    assign seg_hs  = m_axis_tx_seg_tvalid && m_axis_tx_seg_tready;

    assign s_axis_tx_metadata_tready = (state_q == ST_IDLE);
    assign m_axis_tx_status_tvalid   = status_valid_q && !net_rst;
    assign m_axis_tx_status_tdata    = {code_q, session_q};
    assign m_axis_tx_seg_tvalid      = in_data && s_axis_tx_data_tvalid;
    assign s_axis_tx_data_tready     = in_data && m_axis_tx_seg_tready;
    assign m_axis_tx_seg_tdata       = s_axis_tx_data_tdata;
    assign m_axis_tx_seg_tkeep       = s_axis_tx_data_tkeep;
    assign m_axis_tx_seg_tlast       = s_axis_tx_data_tlast;
    assign m_tx_seg_session          = net_rst ? '0 : session_q;
    assign stat_pkts_ok              = ok_q;
    assign stat_pkts_rej             = rej_q;

    always_comb begin
        open_sel = 1'b0;
        for (int i = 0; i < NUM_SESSIONS; i++) begin
            if (32'(session_q) == i) begin
                open_sel = session_open[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        session_d      = session_q;
        code_d         = code_q;
        status_valid_d = status_valid_q;
        ok_d           = ok_q;
        rej_d          = rej_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tx_metadata_tvalid) begin
                    session_d = s_axis_tx_metadata_tdata;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((32'(session_q) >= NUM_SESSIONS) || !open_sel) begin
                    code_d = CODE_CLOSED;
                end else if (32'(credits) < MAX_PKT_WORDS) begin
                    code_d = CODE_NO_SPACE;
                end else begin
                    code_d = CODE_OK;
                end
                status_valid_d = 1'b1;
                state_d        = ST_STATUS;
            end
            ST_STATUS: begin
                if (m_axis_tx_status_tready) begin
                    status_valid_d = 1'b0;
                    if (code_q == CODE_OK) begin
                        ok_d    = ok_q + 32'd1;
                        state_d = ST_DATA;
                    end else begin
                        rej_d   = rej_q + 32'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (seg_hs && m_axis_tx_seg_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            state_q        <= ST_IDLE;
            session_q      <= '0;
            code_q         <= CODE_OK;
            status_valid_q <= 1'b0;
            ok_q           <= '0;
            rej_q          <= '0;
        end else begin
            state_q        <= state_d;
            session_q      <= session_d;
            code_q         <= code_d;
            status_valid_q <= status_valid_d;
            ok_q           <= ok_d;
            rej_q          <= rej_d;
        end
    end

    tx_credit_counter #(
        .TX_BUF_WORDS (TX_BUF_WORDS),
        .CW           (CW)
    ) u_credit (
        .clk       (net_clk),
        .rst       (net_rst),
        .consume   (seg_hs),
        .ret_valid (s_credit_valid),
        .ret_words (s_credit_words),
        .credits   (credits),
        .overflow  (credit_overflow)
    );

endmodule

// File: tb/tb_tcp_tx_app_responder.sv
// tb/tb_tcp_tx_app_responder.sv - self-checking bench for tcp_tx_app_responder
module tb_tcp_tx_app_responder;

    logic        clk = 1'b0;
    logic        net_rst;
    logic [15:0] session_open;
    logic        meta_tvalid, meta_tready;
    logic [15:0] meta_tdata;
    logic        status_tvalid, status_tready;
    logic [23:0] status_tdata;
    logic        data_tvalid, data_tready;
    logic [63:0] data_tdata;
    logic [7:0]  data_tkeep;
    logic        data_tlast;
    logic        seg_tvalid, seg_tready;
    logic [63:0] seg_tdata;
    logic [7:0]  seg_tkeep;
    logic        seg_tlast;
    logic [15:0] seg_session;
    logic        ret_valid;
    logic [15:0] ret_words;
    logic [10:0] credits;
    logic        credit_overflow;
    logic [31:0] stat_ok, stat_rej;

    int checks = 0;
    int errors = 0;
    bit bp = 1'b0;
    bit rand_ret = 1'b0;

    always #5 clk = ~clk;

    tcp_tx_app_responder dut (
        .net_clk                   (clk),
        .net_rst                   (net_rst),
        .session_open              (session_open),
        .s_axis_tx_metadata_tvalid (meta_tvalid),
        .s_axis_tx_metadata_tready (meta_tready),
        .s_axis_tx_metadata_tdata  (meta_tdata),
        .m_axis_tx_status_tvalid   (status_tvalid),
        .m_axis_tx_status_tready   (status_tready),
        .m_axis_tx_status_tdata    (status_tdata),
        .s_axis_tx_data_tvalid     (data_tvalid),
        .s_axis_tx_data_tready     (data_tready),
        .s_axis_tx_data_tdata      (data_tdata),
        .s_axis_tx_data_tkeep      (data_tkeep),
        .s_axis_tx_data_tlast      (data_tlast),
        .m_axis_tx_seg_tvalid      (seg_tvalid),
        .m_axis_tx_seg_tready      (seg_tready),
        .m_axis_tx_seg_tdata       (seg_tdata),
        .m_axis_tx_seg_tkeep       (seg_tkeep),
        .m_axis_tx_seg_tlast       (seg_tlast),
        .m_tx_seg_session          (seg_session),
        .s_credit_valid            (ret_valid),
        .s_credit_words            (ret_words),
        .credits                   (credits),
        .credit_overflow           (credit_overflow),
        .stat_pkts_ok              (stat_ok),
        .stat_pkts_rej             (stat_rej)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of what the block owes its neighbours.
    int          cyc = 0;
    int          m_credits = 1024;
    bit          m_ovf = 1'b0;
    logic [31:0] m_ok = '0, m_rej = '0;
    int          m_hs_cyc = -1;
    logic [15:0] m_session = '0;
    logic [7:0]  m_code = '0;
    bit          m_stat_pending = 1'b0;
    bit          m_in_data = 1'b0;
    bit          rst_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (m_hs_cyc >= 0 && cyc == m_hs_cyc + 1) begin
            logic [15:0] so;
            bit          open_b;
            so     = session_open;
            open_b = (m_session < 16) ? so[m_session[3:0]] : 1'b0;
            if (!open_b)             m_code = 8'h01;
            else if (m_credits < 188) m_code = 8'h02;
            else                     m_code = 8'h00;
        end
        if (m_hs_cyc >= 0 && cyc == m_hs_cyc + 2) begin
            m_stat_pending = 1'b1;
            m_hs_cyc       = -1;
        end

        if (net_rst) begin
            chk("rst_status_valid", status_tvalid, 0);
            chk("rst_seg_valid", seg_tvalid, 0);
            chk("rst_seg_session", seg_session, 0);
            if (rst_prev) begin
                chk("rst_credits", credits, 1024);
                chk("rst_overflow", credit_overflow, 0);
                chk("rst_stat_ok", stat_ok, 0);
                chk("rst_stat_rej", stat_rej, 0);
                chk("rst_meta_ready", meta_tready, 1);
            end
        end else begin
            chk("credits", credits, m_credits);
            chk("overflow", credit_overflow, m_ovf);
            chk("stat_ok", stat_ok, m_ok);
            chk("stat_rej", stat_rej, m_rej);
            chk("meta_ready", meta_tready, !((m_hs_cyc >= 0) || m_stat_pending || m_in_data));
            chk("status_valid", status_tvalid, m_stat_pending);
            if (m_stat_pending) chk("status_data", status_tdata, {m_code, m_session});
            chk("seg_valid", seg_tvalid, m_in_data && data_tvalid);
            chk("data_ready", data_tready, m_in_data && seg_tready);
            if (m_in_data && data_tvalid) begin
                chk("seg_data", seg_tdata, data_tdata);
                chk("seg_keep", seg_tkeep, data_tkeep);
                chk("seg_last", seg_tlast, data_tlast);
                chk("seg_session", seg_session, m_session);
            end
        end

        if (net_rst) begin
            m_credits = 1024; m_ovf = 1'b0; m_ok = '0; m_rej = '0;
            m_hs_cyc = -1; m_stat_pending = 1'b0; m_in_data = 1'b0; m_session = '0;
        end else begin
            bit consume;
            int sum;
            consume = m_in_data && data_tvalid && seg_tready;
            sum = m_credits + (ret_valid ? int'(ret_words) : 0);
            if (consume && sum > 0) sum--;
            if (sum > 1024) begin
                sum   = 1024;
                m_ovf = 1'b1;
            end
            m_credits = sum;
            if (m_stat_pending && status_tready) begin
                m_stat_pending = 1'b0;
                if (m_code == 8'h00) begin
                    m_ok++;
                    m_in_data = 1'b1;
                end else begin
                    m_rej++;
                end
            end
            if (consume && data_tlast) m_in_data = 1'b0;
            if (meta_tvalid && !((m_hs_cyc >= 0) || m_stat_pending || m_in_data)) begin
                m_hs_cyc  = cyc;
                m_session = meta_tdata;
            end
        end
        rst_prev = net_rst;
    end

    initial forever begin
        @(posedge clk); #1;
        seg_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rand_ret) begin
            ret_valid = ($urandom_range(0, 7) == 0);
            ret_words = 16'($urandom_range(0, 20));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    task automatic send_req(input logic [15:0] s);
        int n;
        @(posedge clk); #1;
        meta_tvalid = 1'b1;
        meta_tdata  = s;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (meta_tready) break;
        end
        if (n == 200) chk("meta_timeout", 0, 1);
        @(posedge clk); #1;
        meta_tvalid = 1'b0;
    endtask

    task automatic get_status(input int stall, output logic [23:0] d);
        int k = 0;
        status_tready = 1'b0;
        while (!status_tvalid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) chk("status_timeout", 0, 1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        status_tready = 1'b1;
        d = status_tdata;
        @(posedge clk); #1;
        status_tready = 1'b0;
    endtask

    task automatic send_packet(input int nbeats, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            int n;
            if (gaps && $urandom_range(0, 3) == 0) begin
                data_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            data_tvalid = 1'b1;
            data_tdata  = {$urandom, $urandom};
            data_tkeep  = 8'($urandom);
            data_tlast  = (b == nbeats - 1);
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (data_tready) break;
            end
            if (n == 200) chk("data_timeout", 0, 1);
            @(posedge clk); #1;
        end
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
    endtask

    logic [23:0] d;
    int          nd;

    initial begin
        net_rst = 1'b1; session_open = 16'h0009;
        meta_tvalid = 1'b0; meta_tdata = '0; status_tready = 1'b0;
        data_tvalid = 1'b0; data_tdata = '0; data_tkeep = '0; data_tlast = 1'b0;
        ret_valid = 1'b0; ret_words = '0; seg_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_credits", credits, 1024);
        net_rst = 1'b0;

        send_req(16'd3);
        get_status(0, d);
        chk("grant_s3", d, 24'h000003);
        send_packet(4, 1'b0);
        chk("credits_after_4", credits, 1020);
        chk("stat_ok_1", stat_ok, 1);

        send_req(16'd3);
        get_status(0, d);
        data_tvalid = 1'b1; data_tdata = 64'h0123_4567_89ab_cdef; data_tkeep = 8'hff; data_tlast = 1'b1;
        ret_valid = 1'b1; ret_words = 16'd10;
        @(posedge clk); #1;
        data_tvalid = 1'b0; data_tlast = 1'b0; ret_valid = 1'b0; ret_words = '0;
        chk("sat_credits", credits, 1024);
        chk("sat_overflow", credit_overflow, 1);

        data_tvalid = 1'b1;
        send_req(16'd5);
        get_status(1, d);
        chk("closed_s5", d, 24'h010005);
        send_req(16'd20);
        get_status(0, d);
        chk("closed_s20", d, 24'h010014);
        chk("stat_rej_2", stat_rej, 2);

        send_req(16'd3);
        get_status(5, d);
        chk("stall_grant", d, 24'h000003);
        bp = 1'b1;
        session_open = 16'h0001;
        send_packet(3, 1'b1);
        session_open = 16'h0009;
        bp = 1'b0;

        nd = m_credits - 100;
        send_req(16'd3);
        get_status(0, d);
        send_packet(nd, 1'b0);
        chk("drained", credits, 100);
        send_req(16'd0);
        ret_valid = 1'b1; ret_words = 16'd200;
        @(posedge clk); #1;
        ret_valid = 1'b0; ret_words = '0;
        get_status(1, d);
        chk("no_space", d, 24'h020000);
        chk("refilled", credits, 300);
        send_req(16'd0);
        get_status(0, d);
        chk("retry_ok", d, 24'h000000);
        send_packet(1, 1'b0);
        chk("after_retry", credits, 299);

        send_req(16'd3);
        get_status(0, d);
        data_tvalid = 1'b1; data_tdata = {$urandom, $urandom}; data_tlast = 1'b0;
        @(posedge clk); #1;
        data_tdata = {$urandom, $urandom};
        net_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        data_tvalid = 1'b0;
        chk("rst_mid_credits", credits, 1024);
        chk("rst_mid_overflow", credit_overflow, 0);
        net_rst = 1'b0;
        send_req(16'd3);
        get_status(0, d);
        chk("post_rst_grant", d, 24'h000003);
        send_packet(3, 1'b1);

        bp = 1'b1;
        rand_ret = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) session_open = 16'($urandom);
            send_req(16'($urandom_range(0, 19)));
            get_status($urandom_range(0, 3), d);
            if (d[23:16] == 8'h00) send_packet($urandom_range(1, 8), 1'b1);
        end
        rand_ret = 1'b0;
        @(posedge clk); #1;
        ret_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_tx_app_responder.md
TCP_TX_APP_RESPONDER -- requirements
Module: tcp_tx_app_responder

Interface
REQ-001 Parameter NUM_SESSIONS, default 16, meaning the number of valid session IDs (0..NUM_SESSIONS-1).
REQ-002 Parameter TX_BUF_WORDS, default 1024, meaning the total 64-bit TX buffer credits.
REQ-003 Parameter MAX_PKT_WORDS, default 188, meaning the credits required before a send is granted.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 net_clk  in  1  clock.
REQ-006 net_rst  in  1  synchronous, active-high reset.
REQ-007 session_open  in  NUM_SESSIONS  per-session "connection established" bitmap.
REQ-008 s_axis_tx_metadata  valid/ready/data[15:0]  send request carrying the session ID.
REQ-009 m_axis_tx_status  valid/ready/data[23:0]  reply: [15:0] session, [23:16] code.
REQ-010 s_axis_tx_data  valid/ready/data[63:0]/keep[7:0]/last  application payload.
REQ-011 m_axis_tx_seg  valid/ready/data[63:0]/keep[7:0]/last  payload toward the TCP engine.
REQ-012 m_tx_seg_session  out  16  session of the packet currently on m_axis_tx_seg.
REQ-013 s_credit_valid / s_credit_words  in  1 / 16  buffer words freed by the engine.
REQ-014 credits  out  clog2(TX_BUF_WORDS+1)  current free-credit count.
REQ-015 credit_overflow  out  1  sticky error flag.
REQ-016 stat_pkts_ok / stat_pkts_rej  out  32 each  granted and rejected request counters.

Function
REQ-017 The FSM SHALL have states IDLE, CHECK, STATUS, DATA.
REQ-018 In IDLE, s_axis_tx_metadata.ready SHALL be 1; on handshake the session is latched and the FSM goes to CHECK.
REQ-019 CHECK SHALL last exactly 1 cycle and compute the code as follows: 0x01 (CLOSED) if session >= NUM_SESSIONS or session_open[session]=0; else 0x02 (NO_SPACE) if credits < MAX_PKT_WORDS; else 0x00 (OK). The FSM then goes to STATUS.
REQ-020 In STATUS, tx_status.valid SHALL be 1 with data stable until ready; on handshake the FSM goes to DATA if the code is OK, else to IDLE.
REQ-021 Status valid SHALL assert exactly 2 cycles after the metadata handshake.
REQ-022 In DATA, the payload path SHALL be zero-latency pass-through: seg.valid = data.valid, data.ready = seg.ready, with data/keep/last passed unmodified.
REQ-023 Outside DATA, s_axis_tx_data.ready and m_axis_tx_seg.valid SHALL both be 0.
REQ-024 A seg handshake with last=1 SHALL return the FSM to IDLE.
REQ-025 m_tx_seg_session SHALL hold the latched session throughout DATA.
REQ-026 Each seg handshake SHALL consume 1 credit; credits SHALL floor at 0 and never underflow.
REQ-027 A cycle with both a consume and a return SHALL apply net = credits + s_credit_words - 1 in that same cycle.
REQ-028 A result above TX_BUF_WORDS SHALL saturate at TX_BUF_WORDS and set credit_overflow, which stays set until reset.
REQ-029 stat_pkts_ok SHALL increment on an OK status handshake; stat_pkts_rej SHALL increment on a non-OK status handshake; both wrap modulo 2^32.
REQ-030 The CHECK decision SHALL use the pre-update credits value of that cycle.
REQ-031 A session closing mid-DATA SHALL NOT abort the packet; the payload completes.

Reset
REQ-032 While net_rst=1, the FSM SHALL be in IDLE, credits = TX_BUF_WORDS, and credit_overflow = 0.
REQ-033 While net_rst=1, all valid outputs SHALL be 0, both stats SHALL be 0, and m_tx_seg_session SHALL be 0.
REQ-034 Reset mid-packet SHALL discard the remaining packet state; metadata ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-035 Package tcp_app_pkg SHALL hold: the status code constants (OK/CLOSED/NO_SPACE), the state enum, the session width (16), the status width (24) and the data width (64).
REQ-036 The credit arithmetic (REQ-026..REQ-028) SHALL be one sub-module, tx_credit_counter; the FSM and pass-through stay in the top.

Verification
REQ-037 Session 3 open, credits 1024, request session 3, 4-beat packet -> status 0x000003 two cycles after the request; 4 beats pass unchanged; credits 1020; stat_pkts_ok = 1.
REQ-038 Request session 5 with session_open[5]=0, and separately request session 20 -> status 0x010005 and 0x010014; no data accepted; stat_pkts_rej = 2.
REQ-039 Credits drained to 100, request session 0 -> status 0x020000; in the same window return 200 words -> credits 300; a retry is granted OK.
REQ-040 Credits 1020, return 10 in the same cycle as a consume -> credits saturate at 1024 and credit_overflow = 1.
REQ-041 Hold status ready=0 for 5 cycles -> status data stable; tx_data.ready stays 0 until the status handshake.
REQ-042 Assert reset at beat 2 of 4 -> all valids 0, credits 1024; a new request after reset is handled normally.
